// File: rtl/relprime_sequencer.sv
// relPrime controller: smallest m >= 2 coprime to n, via subtractive Euclid on a shared ALU.
// Optional RELPRIME_CYCLE_COUNT_EN adds a saturating busy-cycle counter output.
module relprime_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [WIDTH-1:0] register_value,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_lt,
  input  logic             alu_eq
`ifdef RELPRIME_CYCLE_COUNT_EN
  ,
  output logic [31:0]      cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE, INIT, LOAD, SUB_AB, SUB_BA, NEXT, DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] n, m, a, b;
  logic [WIDTH-1:0] m_inc;
  logic             start_q;
  logic             start_edge;

  assign start_edge = start & ~start_q;
  assign m_inc      = m + WIDTH'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      n       <= '0;
      m       <= '0;
      a       <= '0;
      b       <= '0;
      start_q <= 1'b0;
      out     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      alu_req <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
    end else begin
      start_q <= start;
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            n     <= register_value;
            done  <= 1'b0;
            error <= 1'b0;
            if (register_value == '0) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= INIT;
            end
          end
        end
        INIT: begin
          m     <= WIDTH'(2);
          state <= LOAD;
        end
        LOAD: begin
          a       <= n;
          b       <= m;
          alu_req <= 1'b1;
          alu_a   <= n;
          alu_b   <= m;
          state   <= SUB_AB;
        end
        SUB_AB: begin
          if (alu_gnt) begin
            if (alu_eq) begin
              alu_req <= 1'b0;
              if (a == WIDTH'(1)) begin
                out   <= m;
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end else begin
                state <= NEXT;
              end
            end else if (alu_lt) begin
              alu_a <= b;
              alu_b <= a;
              state <= SUB_BA;
            end else begin
              a     <= alu_result;
              alu_a <= alu_result;
            end
          end
        end
        SUB_BA: begin
          if (alu_gnt) begin
            b     <= alu_result;
            alu_a <= a;
            alu_b <= alu_result;
            state <= SUB_AB;
          end
        end
        NEXT: begin
          m <= m_inc;
          if (m_inc == '0) begin
            error <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RELPRIME_CYCLE_COUNT_EN
  logic accept;

  assign accept = start_edge && (state == IDLE || state == DONE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cycles <= '0;
    end else if (accept) begin
      cycles <= '0;
    end else if (busy && cycles != '1) begin
      cycles <= cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/relprime_sequencer.md
# relprime_sequencer

Control sequencer for the relPrime computation. For the 16-bit operand on `register_value` it finds the smallest m ≥ 2 with gcd(n, m) = 1. It runs subtraction-based Euclid on a shared 16-bit ALU that it does not own. It requests the ALU one operation at a time through a req/gnt handshake, so the CPU datapath and this block can time-share a single subtractor.

## Interface
- `WIDTH`, 16, operand and result width
- `CLK`  in  1  clock; all state changes on rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `start`  in  1  request; acted on at a rising edge of `start` (0→1) while IDLE or DONE
- `register_value`  in  WIDTH  operand n; captured in the cycle the start edge is detected
- `out`  out  WIDTH  result m; valid while `done`=1
- `busy`  out  1  computation in progress
- `done`  out  1  result/error valid; held until next accepted start
- `error`  out  1  operand invalid (n = 0) or m wrapped; qualifies `done`
- `alu_req`  out  1  controller needs the ALU this cycle
- `alu_gnt`  in  1  arbiter grant; the ALU result is consumed only when `alu_req && alu_gnt`
- `alu_a`, `alu_b`  out  WIDTH  ALU operands; the ALU computes `alu_a - alu_b`
- `alu_result`  in  WIDTH  `alu_a - alu_b` (mod 2^WIDTH), combinational, same cycle
- `alu_lt`, `alu_eq`  in  1  unsigned `alu_a < alu_b`, `alu_a == alu_b`

## Operation
- State machine states: IDLE, INIT, LOAD, SUB_AB, SUB_BA, NEXT, DONE.
- Internal registers: `n`, `m`, `a`, `b`, plus `start_q` for edge detection.
- IDLE/DONE on start edge:
  - capture `n` and clear `done` and `error`
  - if n = 0: set `error` and `done`, go to DONE
  - otherwise go to INIT
- INIT: m ← 2, go to LOAD.
- LOAD: a ← n, b ← m, go to SUB_AB.
- SUB_AB: `alu_req`=1, `alu_a`=a, `alu_b`=b. On grant:
  - `alu_eq`: gcd = a. If a = 1, then out ← m and go to DONE; otherwise go to NEXT.
  - `alu_lt`: go to SUB_BA.
  - otherwise: a ← `alu_result`, stay in SUB_AB.
- SUB_BA: `alu_req`=1, `alu_a`=b, `alu_b`=a. On grant, b ← `alu_result`, then go to SUB_AB.
- NEXT: m ← m+1 using a local incrementer, not the ALU. If m+1 wraps to 0, set `error` and go to DONE; otherwise go to LOAD.
- Without a grant, the state and all registers hold. `alu_a` and `alu_b` stay stable while `alu_req` is high.
- `alu_req` is 0 in every state except SUB_AB and SUB_BA.
- A start edge while `busy` is ignored. No abort exists except reset.
- n = 1 gives out = 2.

## Timing
- Reset values:
  - state IDLE
  - `out`=0, `busy`=0, `done`=0, `error`=0, `alu_req`=0, `alu_a`=0, `alu_b`=0
  - `start_q`=0, so a `start` already high when reset is released counts as an edge
- `busy` rises the cycle after the start edge and stays high in INIT through NEXT.
- `done` rises in the same edge that `busy` falls.
- Latency with `alu_gnt` tied high:
  - 1 (INIT) + Σ over each tried m of [1 (LOAD) + subtract steps + 1 (NEXT, on failed m only)]
  - exactly one subtract step per granted cycle
- Reset mid-operation returns to IDLE immediately, with all outputs at their reset values.

## Configuration
- `RELPRIME_CYCLE_COUNT_EN`
  - Defined: adds output `cycles` [31:0]. It is cleared on an accepted start and incremented every cycle `busy`=1, including stalled cycles. It saturates at 2^32−1 and is held while DONE.
  - Undefined: no port and no counter.

## Test plan
- n=34596, `alu_gnt`=1, start pulse → `done`=1, `error`=0, `out`=5 within 50,000 cycles.
- n=1 → `out`=2. n=35 → `out`=2. n=30 → `out`=7. Check each cycle count against the latency formula.
- n=0 → `done`=1, `error`=1 one cycle after the edge. `busy` never asserts.
- n=30, `alu_gnt` randomly 0 on 50% of cycles → `out`=7. `alu_a` and `alu_b` stay stable throughout every stall.
- Start held high across DONE → no restart. Start edge while busy → ignored. Reset asserted mid-run → `busy`=0 and `out`=0 asynchronously; a fresh run then yields the correct result.
- With `RELPRIME_CYCLE_COUNT_EN` defined: `cycles` equals the number of `busy` cycles for n=30, with both grant patterns above.
